// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, lane indices and default widths for
// the fetch/memory-stage bus arbiter.
package mem_arb_pkg;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    // One result-hold lane per requester.
    localparam int NUM_SIDES = 2;
    localparam int SIDE_I    = 0;
    localparam int SIDE_D    = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } arbState_t;

endpackage

// File: rtl/arb_result_hold.sv
// arb_result_hold: per-requester result register. It captures bus read data
// on this side's ack and flags it valid until the pipeline advances. With
// MEM_ARB_BYPASS_EN the ack data is also forwarded combinationally.
module arb_result_hold
    import mem_arb_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          ack,
    input  logic          consume,
    input  logic [DW-1:0] busRdata,
    output logic          done,
    output logic          valid,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] hold;
    logic          capture;
    logic          setValid;

    // A flushed requester (req low at ack time) gets nothing.
    assign capture = ack & req;

`ifdef MEM_ARB_BYPASS_EN
    // The ack cycle already counts as done. If the pipeline advances in
    // that same cycle, it has taken the forwarded word, so nothing is left
    // to hold.
    assign done     = valid | ack;
    assign rdata    = ack ? busRdata : hold;
    assign setValid = capture & ~consume;
`else
    // Results are only visible from the hold register, so there is no
    // combinational path from the bus into done.
    assign done     = valid;
    assign rdata    = hold;
    assign setValid = capture;
`endif

    // Hold register and valid flag. A fresh capture wins over the consume
    // clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= 1'b0;
            hold  <= '0;
        end else begin
            if (capture) begin
                hold <= busRdata;
            end
            if (setValid) begin
                valid <= 1'b1;
            end else if (consume) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory bus between fetch and the
// memory stage. Data has priority. Transactions run back-to-back on ack.
// Early results are held until pipe_en, and arb_stall feeds the hazard unit.
// Optional feature: define MEM_ARB_BYPASS_EN to forward ack data and release
// the stall in the ack cycle.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_req,
    input  logic [AW-1:0]   inst_addr,
    output logic [DW-1:0]   inst_rdata,
    input  logic            data_req,
    input  logic            data_wr,
    input  logic [DW/8-1:0] data_wstrb,
    input  logic [AW-1:0]   data_addr,
    input  logic [DW-1:0]   data_wdata,
    output logic [DW-1:0]   data_rdata,
    input  logic            pipe_en,
    output logic            arb_stall,
    output logic            bus_req,
    output logic            bus_wr,
    output logic [DW/8-1:0] bus_wstrb,
    output logic [AW-1:0]   bus_addr,
    output logic [DW-1:0]   bus_wdata,
    input  logic            bus_ack,
    input  logic [DW-1:0]   bus_rdata
);

    arbState_t state;
    arbState_t stateNext;

    logic [NUM_SIDES-1:0]         sideReq;
    logic [NUM_SIDES-1:0]         sideAck;
    logic [NUM_SIDES-1:0]         sideDone;
    logic [NUM_SIDES-1:0]         sideValid;
    logic [NUM_SIDES-1:0][DW-1:0] sideRdata;

    logic ackI;
    logic ackD;
    logic iPend;
    logic dPend;
    logic busFree;
    logic issueI;
    logic issueD;

    // An ack only counts for the side that owns the bus. A stray ack in
    // IDLE is ignored.
    assign ackI = bus_ack & (state == IBUSY);
    assign ackD = bus_ack & (state == DBUSY);

    // Lane order follows SIDE_D / SIDE_I.
    assign sideReq = {data_req, inst_req};
    assign sideAck = {ackD, ackI};

    for (genvar g = 0; g < NUM_SIDES; g++) begin : gSide
        arb_result_hold #(.DW(DW)) uHold (
            .clk      (clk),
            .rst      (rst),
            .req      (sideReq[g]),
            .ack      (sideAck[g]),
            .consume  (pipe_en),
            .busRdata (bus_rdata),
            .done     (sideDone[g]),
            .valid    (sideValid[g]),
            .rdata    (sideRdata[g])
        );
    end

    // Pending is judged after the completion in this cycle. The side being
    // acked is finished and must not be re-issued.
    assign dPend   = data_req & ~sideValid[SIDE_D] & ~ackD;
    assign iPend   = inst_req & ~sideValid[SIDE_I] & ~ackI;
    assign busFree = (state == IDLE) | bus_ack;

    // Next-state and issue decision: data first, then fetch, else go idle.
    always_comb begin
        stateNext = state;
        issueD    = 1'b0;
        issueI    = 1'b0;
        if (busFree) begin
            if (dPend) begin
                stateNext = DBUSY;
                issueD    = 1'b1;
            end else if (iPend) begin
                stateNext = IBUSY;
                issueI    = 1'b1;
            end else begin
                stateNext = IDLE;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Bus request registers. They are loaded on issue, held while a
    // transaction waits for its ack, and bus_req drops when the bus goes idle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus_req   <= 1'b0;
            bus_wr    <= 1'b0;
            bus_wstrb <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else if (issueD) begin
            bus_req   <= 1'b1;
            bus_wr    <= data_wr;
            bus_wstrb <= data_wr ? data_wstrb : '0;
            bus_addr  <= data_addr;
            bus_wdata <= data_wdata;
        end else if (issueI) begin
            bus_req   <= 1'b1;
            bus_wr    <= 1'b0;
            bus_wstrb <= '0;
            bus_addr  <= inst_addr;
        end else if (busFree) begin
            bus_req   <= 1'b0;
        end
    end

    assign arb_stall = rst & ((inst_req & ~sideDone[SIDE_I]) |
                              (data_req & ~sideDone[SIDE_D]));

    assign inst_rdata = sideRdata[SIDE_I];
    assign data_rdata = sideRdata[SIDE_D];

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic. Every cycle is
// checked against a transaction-level reference model of the arbiter.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
`ifdef MEM_ARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic [DW-1:0] inst_rdata;
    logic          data_req;
    logic          data_wr;
    logic [3:0]    data_wstrb;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic [DW-1:0] data_rdata;
    logic          pipe_en;
    logic          arb_stall;
    logic          bus_req;
    logic          bus_wr;
    logic [3:0]    bus_wstrb;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_ack;
    logic [DW-1:0] bus_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .pipe_en(pipe_en), .arb_stall(arb_stall),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    int checks   = 0;
    int failures = 0;
    bit pipeDither = 1'b0;
    int age = 0;

    logic          sStall;
    logic [DW-1:0] sIRdata, sDRdata;

    // Reference model: the bus owner (0 none, 1 fetch, 2 data), what the
    // bus shows, and each side's captured result.
    int            mOwner;
    logic          mReq, mWr;
    logic [3:0]    mStrb;
    logic [AW-1:0] mAddr;
    logic [DW-1:0] mWdata;
    logic          mIValid, mDValid;
    logic [DW-1:0] mIHold, mDHold;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock. Entered just after a rising edge with inputs already set.
    // Returns just after the next rising edge.
    task automatic cycle();
        logic ackI, ackD, iDone, dDone, expStall, wantI, wantD, iVal, dVal;
        #1;
        if (rst && !arb_stall) pipe_en = pipeDither ? ($urandom_range(3) != 0) : 1'b1;
        else pipe_en = 1'b0;
        #1;
        @(negedge clk);
        sStall  = arb_stall;
        sIRdata = inst_rdata;
        sDRdata = data_rdata;
        ackI  = bus_ack && (mOwner == 1);
        ackD  = bus_ack && (mOwner == 2);
        iDone = mIValid || (BYP && ackI);
        dDone = mDValid || (BYP && ackD);
        expStall = rst && ((inst_req && !iDone) || (data_req && !dDone));
        chk("arb_stall", arb_stall, expStall);
        chk("bus_req", bus_req, mReq);
        if (mReq) begin
            chk("bus_addr", bus_addr, mAddr);
            chk("bus_wr", bus_wr, mWr);
            chk("bus_wstrb", bus_wstrb, mStrb);
            if (mWr) chk("bus_wdata", bus_wdata, mWdata);
        end
        if (rst && inst_req && iDone)
            chk("inst_rdata", inst_rdata, (BYP && ackI) ? bus_rdata : mIHold);
        if (rst && data_req && dDone)
            chk("data_rdata", data_rdata, (BYP && ackD) ? bus_rdata : mDHold);

        if (!rst) begin
            mOwner = 0; mReq = 0; mWr = 0; mStrb = 0; mAddr = 0; mWdata = 0;
            mIValid = 0; mDValid = 0; mIHold = 0; mDHold = 0;
        end else begin
            wantD = data_req && !mDValid && !ackD;
            wantI = inst_req && !mIValid && !ackI;
            iVal = mIValid && !pipe_en;
            dVal = mDValid && !pipe_en;
            if (ackI && inst_req) begin mIHold = bus_rdata; iVal = !(BYP && pipe_en); end
            if (ackD && data_req) begin mDHold = bus_rdata; dVal = !(BYP && pipe_en); end
            if (mOwner == 0 || ackI || ackD) begin
                if (wantD) begin
                    mOwner = 2; mReq = 1; mWr = data_wr;
                    mStrb = data_wr ? data_wstrb : 4'h0;
                    mAddr = data_addr; mWdata = data_wdata;
                end else if (wantI) begin
                    mOwner = 1; mReq = 1; mWr = 0; mStrb = 0; mAddr = inst_addr;
                end else begin
                    mOwner = 0; mReq = 0;
                end
            end
            mIValid = iVal;
            mDValid = dVal;
        end
        @(posedge clk);
        #1;
    endtask

    // Memory responder: acks once a transaction has been on the bus for lat cycles.
    task automatic busCycle(input int lat, input logic [DW-1:0] rd);
        logic wasReq, acked;
        wasReq    = bus_req;
        acked     = bus_req && (age >= lat - 1);
        bus_ack   = acked;
        bus_rdata = rd;
        cycle();
        if (acked) age = 0;
        else if (wasReq) age++;
        bus_ack = 1'b0;
    endtask

    task automatic quiet(input int n);
        inst_req = 0; data_req = 0; data_wr = 0; bus_ack = 0; bus_rdata = 0;
        for (int i = 0; i < n; i++) cycle();
        age = 0;
    endtask

    initial begin
        int cnt, nLog;
        bit got, advance;
        logic [AW-1:0] logA [8];

        rst = 0; inst_req = 1; inst_addr = 32'h40; data_req = 1; data_wr = 1;
        data_wstrb = 4'hF; data_addr = 32'h100; data_wdata = 32'hFFFF_FFFF;
        pipe_en = 0; bus_ack = 0; bus_rdata = 0;
        mOwner = 0; mReq = 0; mWr = 0; mStrb = 0; mAddr = 0; mWdata = 0;
        mIValid = 0; mDValid = 0; mIHold = 0; mDHold = 0;
        @(posedge clk);
        #1;

        // Reset: outputs cleared, stall forced low despite requests.
        cycle();
        cycle();
        chk("rst_stall", sStall, 0);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_wr", bus_wr, 0);
        chk("rst_bus_wstrb", bus_wstrb, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        rst = 1;
        quiet(2);

        // Lone fetch, ack in the first bus cycle.
        inst_req = 1; inst_addr = 32'h40; cnt = 0; got = 0;
        for (int k = 0; k < 8 && !got; k++) begin
            busCycle(1, (k == 1) ? 32'h2408_0005 : 32'h0);
            if (k == 0) begin
                chk("t1_bus_req", bus_req, 1);
                chk("t1_bus_addr", bus_addr, 32'h40);
                chk("t1_bus_wstrb", bus_wstrb, 0);
            end
            if (sStall) cnt++;
            else begin got = 1; chk("t1_inst_rdata", sIRdata, 32'h2408_0005); end
        end
        chk("t1_done", got, 1);
        chk("t1_stall_cycles", cnt, BYP ? 1 : 2);
        quiet(2);

        // Simultaneous load and fetch, 2-cycle latency.
        inst_req = 1; inst_addr = 32'h44; data_req = 1; data_wr = 0; data_addr = 32'h100;
        cnt = 0; got = 0; nLog = 0;
        for (int k = 0; k < 12 && !got; k++) begin
            if (bus_req && nLog < 8) begin logA[nLog] = bus_addr; nLog++; end
            busCycle(2, (bus_addr == 32'h100) ? 32'hAAAA_0001 : 32'hBBBB_0002);
            if (sStall) cnt++;
            else begin
                got = 1;
                chk("t2_data_rdata", sDRdata, 32'hAAAA_0001);
                chk("t2_inst_rdata", sIRdata, 32'hBBBB_0002);
            end
        end
        chk("t2_done", got, 1);
        chk("t2_stall_cycles", cnt, BYP ? 4 : 5);
        chk("t2_bus_cycles", nLog, 4);
        chk("t2_addr0", logA[0], 32'h100);
        chk("t2_addr1", logA[1], 32'h100);
        chk("t2_addr2", logA[2], 32'h44);
        chk("t2_addr3", logA[3], 32'h44);
        quiet(2);

        // Store, 3-cycle latency.
        data_req = 1; data_wr = 1; data_wstrb = 4'b0011; data_wdata = 32'hDEAD_BEEF;
        data_addr = 32'h200; cnt = 0; got = 0;
        for (int k = 0; k < 12 && !got; k++) begin
            if (bus_req) begin
                chk("t3_bus_wr", bus_wr, 1);
                chk("t3_bus_wstrb", bus_wstrb, 4'b0011);
                chk("t3_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
            end
            busCycle(3, 32'h0BAD_F00D);
            if (sStall) cnt++; else got = 1;
        end
        chk("t3_done", got, 1);
        chk("t3_stall_cycles", cnt, BYP ? 3 : 4);
        busCycle(3, 32'h0);
        chk("t3_dvalid_cleared", sStall, 1);
        chk("t3_reissue", bus_req, 1);
        data_req = 0;
        busCycle(1, 32'h9);
        chk("t3_discard_stall", sStall, 0);
        chk("t3_discard_idle", bus_req, 0);
        quiet(2);

        // Fetch completes early while a 5-cycle load follows it.
        inst_req = 1; inst_addr = 32'h80;
        busCycle(5, 32'h0);
        data_req = 1; data_wr = 0; data_addr = 32'h300;
        bus_ack = 1; bus_rdata = 32'h1111_2222;
        cycle();
        bus_ack = 0; age = 0;
        chk("t4_stall_on_load", sStall, 1);
        got = 0;
        for (int k = 0; k < 16 && !got; k++) begin
            if (bus_req) chk("t4_no_refetch", bus_addr, 32'h300);
            busCycle(5, 32'h3333_4444);
            if (sStall) chk("t4_inst_held", sIRdata, 32'h1111_2222);
            else begin
                got = 1;
                chk("t4_inst_rdata", sIRdata, 32'h1111_2222);
                chk("t4_data_rdata", sDRdata, 32'h3333_4444);
            end
        end
        chk("t4_done", got, 1);
        quiet(2);

        // Flush during IBUSY.
        inst_req = 1; inst_addr = 32'hC0;
        busCycle(9, 32'h0);
        inst_req = 0;
        busCycle(9, 32'h0);
        bus_ack = 1; bus_rdata = 32'h5555;
        cycle();
        bus_ack = 0;
        chk("t5_flush_stall", sStall, 0);
        chk("t5_flush_idle", bus_req, 0);
        inst_req = 1;
        busCycle(9, 32'h0);
        chk("t5_ivalid_clear", sStall, 1);
        chk("t5_refetch", bus_req, 1);
        chk("t5_refetch_addr", bus_addr, 32'hC0);
        bus_ack = 1; bus_rdata = 32'h6666;
        cycle();
        bus_ack = 0; bus_rdata = 0;
        if (sStall) cycle();
        chk("t5_refetch_stall", sStall, 0);
        chk("t5_refetch_data", sIRdata, 32'h6666);
        quiet(2);

        // Reset mid-DBUSY, then a late ack.
        data_req = 1; data_wr = 1; data_wstrb = 4'hF; data_wdata = 32'h1234_5678;
        data_addr = 32'h400;
        cycle();
        chk("t6_busy", bus_req, 1);
        rst = 0;
        cycle();
        chk("t6_stall", sStall, 0);
        chk("t6_bus_req", bus_req, 0);
        chk("t6_bus_wr", bus_wr, 0);
        chk("t6_bus_wstrb", bus_wstrb, 0);
        chk("t6_bus_addr", bus_addr, 0);
        chk("t6_bus_wdata", bus_wdata, 0);
        rst = 1; data_req = 0; bus_ack = 1; bus_rdata = 32'h77;
        cycle();
        bus_ack = 0;
        chk("t6_late_ack_stall", sStall, 0);
        chk("t6_late_ack_idle", bus_req, 0);
        quiet(2);

        // Randomized traffic. Requests change only when the pipeline advances.
        pipeDither = 1'b1;
        advance = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            advance = !rst || pipe_en;
            rst = ($urandom_range(249) != 0);
            if (advance) begin
                inst_req   = ($urandom_range(3) != 0);
                inst_addr  = $urandom & 32'hFFFF_FFFC;
                data_req   = ($urandom_range(1) != 0);
                data_wr    = ($urandom_range(2) == 0);
                data_wstrb = 4'($urandom);
                data_addr  = $urandom & 32'hFFFF_FFFC;
                data_wdata = $urandom;
            end else if (inst_req && $urandom_range(29) == 0) begin
                inst_req = 1'b0;
            end
            bus_ack   = bus_req ? ($urandom_range(2) == 0) : ($urandom_range(9) == 0);
            bus_rdata = $urandom;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
